regs_mch: RTL and testbench

REGS_MCH -- requirements
Module: regs_mch

---
 rtl/regs_mch.sv | 197 +++++++++++++++++++
 tb/tb_regs_mch.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_mch.sv
// regs_mch: multi-channel DATA/CTRL/STATUS/START register block with a start/done FSM per channel.
// Optional IRQ_EN/IRQ_STATUS registers and the irq output are compiled in with `define REGS_MCH_IRQ_EN.
module regs_mch #(
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CH_STRIDE  = 'h10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     lb_waddr,
    input  logic [DATA_WIDTH-1:0]     lb_wdata,
    input  logic                      lb_wen,
    input  logic [DATA_WIDTH/8-1:0]   lb_wstrb,
    output logic                      lb_wready,
    input  logic [ADDR_WIDTH-1:0]     lb_raddr,
    input  logic                      lb_ren,
    output logic [DATA_WIDTH-1:0]     lb_rdata,
    output logic                      lb_rvalid,
    output logic [N_CH*32-1:0]        ch_data,
    output logic [N_CH*16-1:0]        ch_ctrl,
    output logic [N_CH-1:0]           ch_start,
    input  logic [N_CH-1:0]           ch_done,
    input  logic [N_CH*4-1:0]         ch_stat
`ifdef REGS_MCH_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int SH = $clog2(CH_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] IRQEN_OFF = ADDR_WIDTH'(N_CH * CH_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] IRQST_OFF = ADDR_WIDTH'(N_CH * CH_STRIDE + 4);
    localparam logic [SH-1:0] OFF_DATA  = SH'(0);
    localparam logic [SH-1:0] OFF_CTRL  = SH'(4);
    localparam logic [SH-1:0] OFF_STAT  = SH'(8);
    localparam logic [SH-1:0] OFF_START = SH'(12);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e      state_q [N_CH];
    state_e      state_d [N_CH];
    logic [31:0] data_q  [N_CH];
    logic [31:0] data_d  [N_CH];
    logic [15:0] ctrl_q  [N_CH];
    logic [15:0] ctrl_d  [N_CH];
    logic [N_CH-1:0] done_q, done_d, err_q, err_d, start_q, start_d, go;
    logic            rvalid_q;
    logic [31:0]     rdata_q, rdata_d;

    // Offsets relative to BASE; addresses below BASE wrap high and decode as unmapped.
    logic [ADDR_WIDTH-1:0] woff, roff, wch, rch;
    logic [SH-1:0]         wreg, rreg;

    assign woff = lb_waddr - BASE;
    assign roff = lb_raddr - BASE;
    assign wch  = woff >> SH;
    assign rch  = roff >> SH;
    assign wreg = woff[SH-1:0];
    assign rreg = roff[SH-1:0];

    assign lb_wready = 1'b1;
    assign lb_rvalid = rvalid_q;
    assign lb_rdata  = rdata_q;
    assign ch_start  = start_q;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ch_data[32*k +: 32] = data_q[k];
            ch_ctrl[16*k +: 16] = ctrl_q[k];
            go[k] = lb_wen && (wch == ADDR_WIDTH'(k)) && (wreg == OFF_START)
                    && lb_wdata[0] && lb_wstrb[0];
        end
    end

    // Register writes and per-channel FSM next state.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            data_d[k]  = data_q[k];
            ctrl_d[k]  = ctrl_q[k];
            state_d[k] = state_q[k];
            done_d[k]  = done_q[k];
            err_d[k]   = err_q[k];
            start_d[k] = 1'b0;
            if (lb_wen && (wch == ADDR_WIDTH'(k)) && (wreg == OFF_DATA)) begin
                for (int b = 0; b < 4; b++)
                    if (lb_wstrb[b]) data_d[k][8*b +: 8] = lb_wdata[8*b +: 8];
            end
            if (lb_wen && (wch == ADDR_WIDTH'(k)) && (wreg == OFF_CTRL)) begin
                for (int b = 0; b < 2; b++)
                    if (lb_wstrb[b]) ctrl_d[k][8*b +: 8] = lb_wdata[8*b +: 8];
            end
            case (state_q[k])
                IDLE: begin
                    if (go[k]) begin
                        state_d[k] = BUSY;
                        start_d[k] = 1'b1;
                        done_d[k]  = 1'b0;
                        err_d[k]   = 1'b0;
                    end
                end
                BUSY: begin
                    // A restart coinciding with completion is taken as a fresh start.
                    if (go[k] && ch_done[k]) begin
                        start_d[k] = 1'b1;
                        done_d[k]  = 1'b0;
                        err_d[k]   = 1'b0;
                    end else if (go[k]) begin
                        err_d[k] = 1'b1;
                    end else if (ch_done[k]) begin
                        state_d[k] = IDLE;
                        done_d[k]  = 1'b1;
                    end
                end
                default: state_d[k] = IDLE;
            endcase
        end
    end

`ifdef REGS_MCH_IRQ_EN
    logic [N_CH-1:0] irq_en_q, irq_en_d, irq_st_q, irq_st_d, irq_set;
    logic            irq_q;

    always_comb begin
        for (int k = 0; k < N_CH; k++)
            irq_set[k] = (state_q[k] == BUSY) && ch_done[k] && !go[k];
        irq_en_d = irq_en_q;
        irq_st_d = irq_st_q;
        if (lb_wen && (woff == IRQEN_OFF) && lb_wstrb[0]) irq_en_d = lb_wdata[N_CH-1:0];
        if (lb_wen && (woff == IRQST_OFF) && lb_wstrb[0]) irq_st_d = irq_st_q & ~lb_wdata[N_CH-1:0];
        irq_st_d = irq_st_d | irq_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en_q <= '0;
            irq_st_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_st_q <= irq_st_d;
            irq_q    <= |(irq_st_d & irq_en_d);
        end
    end

    assign irq = irq_q;
`endif

    // Read mux samples pre-write register state, so same-cycle writes are not visible.
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (rch == ADDR_WIDTH'(k)) begin
                case (rreg)
                    OFF_DATA: rdata_d = data_q[k];
                    OFF_CTRL: rdata_d = {16'h0, ctrl_q[k]};
                    OFF_STAT: rdata_d = {24'h0, 1'b0, err_q[k], done_q[k],
                                         state_q[k] == BUSY, ch_stat[4*k +: 4]};
                    default:  rdata_d = '0;
                endcase
            end
        end
`ifdef REGS_MCH_IRQ_EN
        if (roff == IRQEN_OFF) rdata_d = 32'(irq_en_q);
        if (roff == IRQST_OFF) rdata_d = 32'(irq_st_q);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= IDLE;
                data_q[k]  <= '0;
                ctrl_q[k]  <= 16'h0100;
            end
            done_q   <= '0;
            err_q    <= '0;
            start_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
                ctrl_q[k]  <= ctrl_d[k];
            end
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            rvalid_q <= lb_ren;
            if (lb_ren) rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_regs_mch.sv
// Testbench for regs_mch: directed scenarios plus randomized traffic against a behavioural model.
module tb_regs_mch;

    localparam int B = 'h40;
    localparam int N = 4;
    localparam int S = 'h10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] lb_waddr = '0, lb_raddr = '0;
    logic [31:0] lb_wdata = '0;
    logic        lb_wen = 1'b0, lb_ren = 1'b0;
    logic [3:0]  lb_wstrb = '0;
    logic        lb_wready, lb_rvalid;
    logic [31:0] lb_rdata;
    logic [N*32-1:0] ch_data;
    logic [N*16-1:0] ch_ctrl;
    logic [N-1:0]    ch_start;
    logic [N-1:0]    ch_done = '0;
    logic [N*4-1:0]  ch_stat = '0;
`ifdef REGS_MCH_IRQ_EN
    logic irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regs_mch #(.BASE_ADDR(B), .N_CH(N), .CH_STRIDE(S)) dut (
        .clk(clk), .rst(rst),
        .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wen(lb_wen), .lb_wstrb(lb_wstrb),
        .lb_wready(lb_wready),
        .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
        .ch_data(ch_data), .ch_ctrl(ch_ctrl), .ch_start(ch_start),
        .ch_done(ch_done), .ch_stat(ch_stat)
`ifdef REGS_MCH_IRQ_EN
        , .irq(irq)
`endif
    );

    // Behavioural model of the register map
    logic [31:0] m_data [N];
    logic [15:0] m_ctrl [N];
    bit          m_busy [N];
    bit          m_done [N];
    bit          m_err  [N];
    logic [N-1:0] m_start;
    logic         m_rvalid;
    logic [31:0]  m_rdata;
    logic [N-1:0] m_irq_en, m_irq_st;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_data[k] = 0; m_ctrl[k] = 16'h100;
            m_busy[k] = 0; m_done[k] = 0; m_err[k] = 0;
        end
        m_start = 0; m_rvalid = 0; m_rdata = 0; m_irq_en = 0; m_irq_st = 0;
    endfunction

    function automatic logic [31:0] m_read(int addr);
        int off, ch, r;
        logic [3:0] st;
        off = addr - B;
        if (off < 0) return 32'h0;
`ifdef REGS_MCH_IRQ_EN
        if (off == N*S)     return 32'(m_irq_en);
        if (off == N*S + 4) return 32'(m_irq_st);
`endif
        ch = off / S;
        r  = off % S;
        if (ch >= N) return 32'h0;
        st = ch_stat[4*ch +: 4];
        case (r)
            0: return m_data[ch];
            4: return {16'h0, m_ctrl[ch]};
            8: return 32'(st) + (m_busy[ch] ? 32'h10 : 0) + (m_done[ch] ? 32'h20 : 0)
                      + (m_err[ch] ? 32'h40 : 0);
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_clock();
        int off, ch, r;
        bit go;
        logic [N-1:0] clr;
        m_rvalid = lb_ren;
        if (lb_ren) m_rdata = m_read(int'(lb_raddr));
        m_start = 0;
        clr = 0;
        ch = -1; r = -1;
        off = int'(lb_waddr) - B;
        if (lb_wen && off >= 0) begin ch = off / S; r = off % S; end
        if (ch >= 0 && ch < N && r == 0)
            for (int b = 0; b < 4; b++) if (lb_wstrb[b]) m_data[ch][8*b +: 8] = lb_wdata[8*b +: 8];
        if (ch >= 0 && ch < N && r == 4)
            for (int b = 0; b < 2; b++) if (lb_wstrb[b]) m_ctrl[ch][8*b +: 8] = lb_wdata[8*b +: 8];
`ifdef REGS_MCH_IRQ_EN
        if (lb_wen && off == N*S && lb_wstrb[0]) m_irq_en = lb_wdata[N-1:0];
        if (lb_wen && off == N*S + 4 && lb_wstrb[0]) clr = lb_wdata[N-1:0];
`endif
        m_irq_st = m_irq_st & ~clr;
        for (int k = 0; k < N; k++) begin
            go = (ch == k) && (r == 12) && lb_wdata[0] && lb_wstrb[0];
            if (!m_busy[k]) begin
                if (go) begin m_busy[k] = 1; m_start[k] = 1; m_done[k] = 0; m_err[k] = 0; end
            end else if (go) begin
                if (ch_done[k]) begin m_start[k] = 1; m_done[k] = 0; m_err[k] = 0; end
                else m_err[k] = 1;
            end else if (ch_done[k]) begin
                m_busy[k] = 0; m_done[k] = 1; m_irq_st[k] = 1'b1;
            end
        end
    endfunction

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s);
        lb_wen = 1; lb_waddr = 16'(a); lb_wdata = d; lb_wstrb = s;
        step();
        lb_wen = 0;
    endtask

    task automatic rd(input int a);
        lb_ren = 1; lb_raddr = 16'(a);
        step();
        lb_ren = 0;
    endtask

    task automatic pulse_done(input logic [N-1:0] d);
        ch_done = d;
        step();
        ch_done = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (lb_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", lb_rvalid); end
        n_cmp++; if (lb_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", lb_rdata); end
        n_cmp++; if (ch_start !== 4'h0) begin n_bad++; $display("FAIL rst_start: got %h want 0", ch_start); end
        n_cmp++; if (ch_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", ch_data); end
        n_cmp++; if (ch_ctrl !== {N{16'h0100}}) begin n_bad++; $display("FAIL rst_ctrl: got %h want 0100 x4", ch_ctrl); end
        n_cmp++; if (lb_wready !== 1'b1) begin n_bad++; $display("FAIL wready: got %b want 1", lb_wready); end
        rst = 1;
        model_reset();
    endtask

    task automatic test_read_after_reset();
        rd(B + 'h14);
        n_cmp++; if (lb_rvalid !== 1'b1) begin n_bad++; $display("FAIL ch1ctrl_rvalid: got %b want 1", lb_rvalid); end
        n_cmp++; if (lb_rdata !== 32'h100) begin n_bad++; $display("FAIL ch1ctrl_rdata: got %h want 00000100", lb_rdata); end
        step();
        n_cmp++; if (lb_rvalid !== 1'b0) begin n_bad++; $display("FAIL rvalid_drop: got %b want 0", lb_rvalid); end
        n_cmp++; if (lb_rdata !== 32'h100) begin n_bad++; $display("FAIL rdata_hold: got %h want 00000100", lb_rdata); end
        rd(B + 'h10);
        n_cmp++; if (lb_rdata !== 32'h0) begin n_bad++; $display("FAIL ch1data_rst: got %h want 0", lb_rdata); end
    endtask

    task automatic test_strobes();
        wr(B + 'h20, 32'hDEADBEEF, 4'b0101);
        n_cmp++; if (ch_data[95:64] !== 32'h00AD00EF) begin n_bad++; $display("FAIL ch2_data_port: got %h want 00ad00ef", ch_data[95:64]); end
        rd(B + 'h20);
        n_cmp++; if (lb_rdata !== 32'h00AD00EF) begin n_bad++; $display("FAIL ch2_data_rd: got %h want 00ad00ef", lb_rdata); end
        wr(B + 'h24, 32'hFFFF1234, 4'b1111);
        n_cmp++; if (ch_ctrl[47:32] !== 16'h1234) begin n_bad++; $display("FAIL ch2_ctrl_port: got %h want 1234", ch_ctrl[47:32]); end
        lb_wen = 1; lb_waddr = 16'(B + 'h20); lb_wdata = 32'h11223344; lb_wstrb = 4'hF;
        lb_ren = 1; lb_raddr = 16'(B + 'h20);
        step();
        lb_wen = 0; lb_ren = 0;
        n_cmp++; if (lb_rdata !== 32'h00AD00EF) begin n_bad++; $display("FAIL rd_during_wr: got %h want 00ad00ef", lb_rdata); end
        rd(B + 'h20);
        n_cmp++; if (lb_rdata !== 32'h11223344) begin n_bad++; $display("FAIL wr_after: got %h want 11223344", lb_rdata); end
    endtask

    task automatic test_start_done();
        logic [3:0] st;
        ch_stat = 16'($urandom);
        st = ch_stat[3:0];
        wr(B + 'hC, 32'h1, 4'h1);
        n_cmp++; if (ch_start !== 4'b0001) begin n_bad++; $display("FAIL start_pulse: got %b want 0001", ch_start); end
        step();
        n_cmp++; if (ch_start !== 4'b0000) begin n_bad++; $display("FAIL start_one_cycle: got %b want 0000", ch_start); end
        rd(B + 'h8);
        n_cmp++; if (lb_rdata !== (32'h10 | 32'(st))) begin n_bad++; $display("FAIL ch0_busy: got %h want %h", lb_rdata, 32'h10 | 32'(st)); end
        pulse_done(4'b0001);
        rd(B + 'h8);
        n_cmp++; if (lb_rdata !== (32'h20 | 32'(st))) begin n_bad++; $display("FAIL ch0_done: got %h want %h", lb_rdata, 32'h20 | 32'(st)); end
        wr(B + 'hC, 32'hFFFFFFFE, 4'hF);
        n_cmp++; if (ch_start !== 4'b0000) begin n_bad++; $display("FAIL start_bit0_zero: got %b want 0000", ch_start); end
        rd(B + 'h8);
        n_cmp++; if (lb_rdata !== (32'h20 | 32'(st))) begin n_bad++; $display("FAIL start0_noeffect: got %h want %h", lb_rdata, 32'h20 | 32'(st)); end
    endtask

    task automatic test_busy_restart();
        logic [3:0] st3, st2;
        ch_stat = 16'($urandom);
        st3 = ch_stat[15:12];
        st2 = ch_stat[11:8];
        wr(B + 'h3C, 32'h1, 4'h1);
        step();
        wr(B + 'h3C, 32'h1, 4'h1);
        n_cmp++; if (ch_start !== 4'b0000) begin n_bad++; $display("FAIL busy_restart_pulse: got %b want 0000", ch_start); end
        rd(B + 'h38);
        n_cmp++; if (lb_rdata !== (32'h50 | 32'(st3))) begin n_bad++; $display("FAIL busy_err: got %h want %h", lb_rdata, 32'h50 | 32'(st3)); end
        ch_done = 4'b1000;
        wr(B + 'h3C, 32'h1, 4'h1);
        ch_done = '0;
        n_cmp++; if (ch_start !== 4'b1000) begin n_bad++; $display("FAIL done_restart_pulse: got %b want 1000", ch_start); end
        rd(B + 'h38);
        n_cmp++; if (lb_rdata !== (32'h10 | 32'(st3))) begin n_bad++; $display("FAIL done_restart_stat: got %h want %h", lb_rdata, 32'h10 | 32'(st3)); end
        pulse_done(4'b0100);
        rd(B + 'h28);
        n_cmp++; if (lb_rdata !== 32'(st2)) begin n_bad++; $display("FAIL idle_done_ignored: got %h want %h", lb_rdata, 32'(st2)); end
        pulse_done(4'b1000);
    endtask

    task automatic test_out_of_range();
        logic [N*32-1:0] ed;
        logic [N*16-1:0] ec;
        rd(B + 'h48);
        n_cmp++; if (lb_rdata !== 32'h0) begin n_bad++; $display("FAIL oor_read: got %h want 0", lb_rdata); end
        rd(B + 'h4);
        rd(B + 'hC);
        n_cmp++; if (lb_rdata !== 32'h0) begin n_bad++; $display("FAIL start_read: got %h want 0", lb_rdata); end
        wr(B + 'h4C, 32'h1, 4'hF);
        n_cmp++; if (ch_start !== 4'b0000) begin n_bad++; $display("FAIL oor_start: got %b want 0000", ch_start); end
        wr(B + 'h48, 32'hFFFFFFFF, 4'hF);
        wr(B + 'h40, 32'hFFFFFFFF, 4'hE);
        wr(0, 32'hA5A5A5A5, 4'hF);
        wr(B + 'h8, 32'hFFFFFFFF, 4'hF);
        for (int k = 0; k < N; k++) begin ed[32*k +: 32] = m_data[k]; ec[16*k +: 16] = m_ctrl[k]; end
        n_cmp++; if (ch_data !== ed) begin n_bad++; $display("FAIL oor_data: got %h want %h", ch_data, ed); end
        n_cmp++; if (ch_ctrl !== ec) begin n_bad++; $display("FAIL oor_ctrl: got %h want %h", ch_ctrl, ec); end
        ch_stat = 16'($urandom);
        wr(B + 'h1C, 32'h1, 4'h1);
        rst = 0;
        #1;
        model_reset();
        n_cmp++; if (ch_start !== 4'b0000) begin n_bad++; $display("FAIL rst_abort_pulse: got %b want 0000", ch_start); end
        #1;
        rst = 1;
        rd(B + 'h18);
        n_cmp++; if (lb_rdata !== 32'(ch_stat[7:4])) begin n_bad++; $display("FAIL rst_abort_stat: got %h want %h", lb_rdata, 32'(ch_stat[7:4])); end
        step();
        n_cmp++; if (ch_start !== 4'b0000) begin n_bad++; $display("FAIL rst_no_late_pulse: got %b want 0000", ch_start); end
    endtask

`ifdef REGS_MCH_IRQ_EN
    task automatic test_irq();
        wr(B + 'h40, 32'h1, 4'h1);
        wr(B + 'hC, 32'h1, 4'h1);
        pulse_done(4'b0001);
        step();
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", irq); end
        rd(B + 'h44);
        n_cmp++; if (lb_rdata !== 32'h1) begin n_bad++; $display("FAIL irq_status: got %h want 1", lb_rdata); end
        wr(B + 'h44, 32'h1, 4'h1);
        step();
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq); end
        wr(B + 'hC, 32'h1, 4'h1);
        ch_done = 4'b0001;
        wr(B + 'h44, 32'h1, 4'h1);
        ch_done = '0;
        step();
        rd(B + 'h44);
        n_cmp++; if (lb_rdata !== 32'h1) begin n_bad++; $display("FAIL irq_set_wins: got %h want 1", lb_rdata); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set_wins_irq: got %b want 1", irq); end
        rd(B + 'h40);
        n_cmp++; if (lb_rdata !== 32'h1) begin n_bad++; $display("FAIL irq_en_rd: got %h want 1", lb_rdata); end
    endtask
`endif

    task automatic test_random();
        logic [N*32-1:0] ed;
        logic [N*16-1:0] ec;
        for (int i = 0; i < 600; i++) begin
            ch_stat  = 16'($urandom);
            ch_done  = 4'($urandom) & 4'($urandom);
            lb_wen   = 1'($urandom);
            lb_ren   = 1'($urandom);
            lb_wdata = $urandom;
            lb_wstrb = 4'($urandom);
            if ($urandom_range(0, 9) < 8)
                lb_waddr = 16'(B + $urandom_range(0, N) * S + 4 * $urandom_range(0, 3));
            else
                lb_waddr = 16'($urandom);
            if ($urandom_range(0, 9) < 8)
                lb_raddr = 16'(B + $urandom_range(0, N) * S + 4 * $urandom_range(0, 3));
            else
                lb_raddr = 16'($urandom);
            step();
            for (int k = 0; k < N; k++) begin ed[32*k +: 32] = m_data[k]; ec[16*k +: 16] = m_ctrl[k]; end
            n_cmp++; if (lb_rvalid !== m_rvalid) begin n_bad++; $display("FAIL rnd_rvalid @%0d: got %b want %b", i, lb_rvalid, m_rvalid); end
            n_cmp++; if (lb_rdata !== m_rdata) begin n_bad++; $display("FAIL rnd_rdata @%0d: got %h want %h", i, lb_rdata, m_rdata); end
            n_cmp++; if (ch_start !== m_start) begin n_bad++; $display("FAIL rnd_start @%0d: got %b want %b", i, ch_start, m_start); end
            n_cmp++; if (ch_data !== ed) begin n_bad++; $display("FAIL rnd_data @%0d: got %h want %h", i, ch_data, ed); end
            n_cmp++; if (ch_ctrl !== ec) begin n_bad++; $display("FAIL rnd_ctrl @%0d: got %h want %h", i, ch_ctrl, ec); end
`ifdef REGS_MCH_IRQ_EN
            n_cmp++; if (irq !== |(m_irq_st & m_irq_en)) begin n_bad++; $display("FAIL rnd_irq @%0d: got %b want %b", i, irq, |(m_irq_st & m_irq_en)); end
`endif
        end
        lb_wen = 0; lb_ren = 0; ch_done = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_read_after_reset();
        test_strobes();
        test_start_done();
        test_busy_restart();
        test_out_of_range();
`ifdef REGS_MCH_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
